// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional opcode checking is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_err,
    output logic [WIDTH-1:0]  alu_srcA,
    output logic [WIDTH-1:0]  alu_srcB,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [CTRL_W-1:0] op_op_q, op_op_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              err_q, err_d;
    logic              pend_err_q, pend_err_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;

    logic              grant;
    logic              accept;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [CTRL_W-1:0] sel_op;
    logic              op_illegal;

    // On a tie the requester that was not served last wins.
    assign grant  = (req0_valid && req1_valid) ? ~last_owner_q : req1_valid;
    assign accept = (state_q == IDLE) && (req0_valid || req1_valid);

    assign req0_ready = rst_n && accept && !grant;
    assign req1_ready = rst_n && accept && grant;

    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;
    assign sel_op = grant ? req1_op : req0_op;

`ifdef ALU_ARB_OPCHECK_EN
    function automatic logic op_is_legal(input logic [CTRL_W-1:0] op);
        case (op)
            CTRL_W'(0), CTRL_W'(1), CTRL_W'(2), CTRL_W'(3), CTRL_W'(5): op_is_legal = 1'b1;
            default:                                                    op_is_legal = 1'b0;
        endcase
    endfunction

    assign op_illegal = !op_is_legal(sel_op);
`else
    assign op_illegal = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_op_d      = op_op_q;
        result_d     = result_q;
        err_d        = err_q;
        pend_err_d   = pend_err_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d    = grant;
                    pend_err_d = op_illegal;
                    // A rejected opcode leaves the ALU operands as they were.
                    if (!op_illegal) begin
                        op_a_d  = sel_a;
                        op_b_d  = sel_b;
                        op_op_d = sel_op;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d     = pend_err_q ? '0 : alu_result;
                err_d        = pend_err_q;
                rsp0_valid_d = !owner_q;
                rsp1_valid_d = owner_q;
                state_d      = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_owner resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_op_q      <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            pend_err_q   <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_op_q      <= op_op_d;
            result_q     <= result_d;
            err_q        <= err_d;
            pend_err_q   <= pend_err_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign alu_srcA   = op_a_q;
    assign alu_srcB   = op_b_q;
    assign alu_ctrl   = op_op_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU.
// Expectations follow ALU_ARB_OPCHECK_EN when it is defined for the build.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_op;
    logic        rsp0_valid, rsp0_ready;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [31:0] alu_srcA, alu_srcB;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;

    int checkCount = 0;
    int errorCount = 0;

    alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_srcA   (alu_srcA),
        .alu_srcB   (alu_srcB),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unlisted codes produce XOR so forwarded illegal codes are visible.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_srcA + alu_srcB;
            3'b001:  alu_result = alu_srcA - alu_srcB;
            3'b010:  alu_result = alu_srcA & alu_srcB;
            3'b011:  alu_result = alu_srcA | alu_srcB;
            3'b101:  alu_result = {31'b0, $signed(alu_srcA) < $signed(alu_srcB)};
            default: alu_result = alu_srcA ^ alu_srcB;
        endcase
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int req, input logic v, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] op);
        if (req == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one transaction from the current IDLE state through the response handshake.
    task automatic serveOne(input int expOwner, input logic [31:0] expResult, input logic expErr,
                            input logic [31:0] expA, input logic [31:0] expB, input logic [2:0] expOp,
                            input bit keep, input int stall);
        int waited = 0;
        int got;
        logic [31:0] heldResult;
        #1;
        while (!req0_ready && !req1_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("accept_wait", waited, 0);
        if (!req0_ready && !req1_ready) return;
        got = req1_ready ? 1 : 0;
        checkOutput("grant_owner", got, expOwner);
        checkOutput("one_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
        @(posedge clk); #1;
        if (!keep) begin
            if (got == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
        checkOutput("exec_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        checkOutput("exec_rsp_valid", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
        checkOutput("alu_srcA", alu_srcA, expA);
        checkOutput("alu_srcB", alu_srcB, expB);
        checkOutput("alu_ctrl", {29'b0, alu_ctrl}, {29'b0, expOp});
        @(posedge clk); #1;
        checkOutput("rsp_valid", {30'b0, rsp0_valid, rsp1_valid}, (expOwner == 0) ? 32'd2 : 32'd1);
        checkOutput("rsp_result", rsp_result, expResult);
        checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, expErr});
        heldResult = rsp_result;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_rsp_valid", {30'b0, rsp0_valid, rsp1_valid}, (expOwner == 0) ? 32'd2 : 32'd1);
            checkOutput("stall_result", rsp_result, heldResult);
            checkOutput("stall_req_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        end
        if (got == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        checkOutput("rsp_done", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        doReset();
        #1;
        checkOutput("reset_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        checkOutput("reset_rsp_valid", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
        checkOutput("reset_result", rsp_result, 32'd0);
        checkOutput("reset_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("reset_alu_a", alu_srcA, 32'd0);

        // Single operation on requester 0.
        applyStimulus(0, 1'b1, 32'd10, 32'd5, 3'b000);
        serveOne(0, 32'd15, 1'b0, 32'd10, 32'd5, 3'b000, 1'b0, 0);

        // Tie straight after reset: requester 0 first, then requester 1.
        doReset();
        applyStimulus(0, 1'b1, 32'd10, 32'd5, 3'b001);
        applyStimulus(1, 1'b1, 32'd10, 32'd5, 3'b010);
        serveOne(0, 32'd5, 1'b0, 32'd10, 32'd5, 3'b001, 1'b0, 0);
        serveOne(1, 32'd0, 1'b0, 32'd10, 32'd5, 3'b010, 1'b0, 0);

        // Fairness with both requests held valid across four operations.
        applyStimulus(0, 1'b1, 32'd6, 32'd2, 3'b000);
        applyStimulus(1, 1'b1, 32'd6, 32'd2, 3'b001);
        serveOne(0, 32'd8, 1'b0, 32'd6, 32'd2, 3'b000, 1'b1, 0);
        serveOne(1, 32'd4, 1'b0, 32'd6, 32'd2, 3'b001, 1'b1, 0);
        serveOne(0, 32'd8, 1'b0, 32'd6, 32'd2, 3'b000, 1'b1, 0);
        serveOne(1, 32'd4, 1'b0, 32'd6, 32'd2, 3'b001, 1'b1, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: requester 1 wins the tie and stalls its response for 5 cycles.
        doReset();
        applyStimulus(0, 1'b1, 32'd1, 32'd1, 3'b000);
        serveOne(0, 32'd2, 1'b0, 32'd1, 32'd1, 3'b000, 1'b0, 0);
        applyStimulus(0, 1'b1, 32'd1, 32'd2, 3'b000);
        applyStimulus(1, 1'b1, 32'd7, 32'd3, 3'b011);
        serveOne(1, 32'd7, 1'b0, 32'd7, 32'd3, 3'b011, 1'b0, 5);
        serveOne(0, 32'd3, 1'b0, 32'd1, 32'd2, 3'b000, 1'b0, 0);

        // Reset while an operation is in EXEC.
        applyStimulus(0, 1'b1, 32'd20, 32'd1, 3'b000);
        #1;
        checkOutput("midrst_accept", {31'b0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        checkOutput("midrst_rsp_valid", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
        checkOutput("midrst_result", rsp_result, 32'd0);
        checkOutput("midrst_alu", {alu_srcA[15:0], alu_srcB[12:0], alu_ctrl}, 32'd0);
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_no_rsp", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
        @(negedge clk);
        doReset();
        applyStimulus(1, 1'b1, 32'd5, 32'd10, 3'b101);
        serveOne(1, 32'd1, 1'b0, 32'd5, 32'd10, 3'b101, 1'b0, 0);

        // Opcode 111 with a=3 b=4.
        applyStimulus(0, 1'b1, 32'd3, 32'd4, 3'b111);
`ifdef ALU_ARB_OPCHECK_EN
        serveOne(0, 32'd0, 1'b1, 32'd5, 32'd10, 3'b101, 1'b0, 0);
`else
        serveOne(0, 32'd7, 1'b0, 32'd3, 32'd4, 3'b111, 1'b0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
